// File: rtl/seq_det_moore_prog.sv
// Programmable-pattern Moore sequence detector with a tick-rate sampler,
// saturating match counter and sticky config-error flag.
module seq_det_moore_prog #(
  parameter int             N           = 8,
  parameter int             LW          = 4,
  parameter int             CW          = 8,
  parameter int             TICK_DIV    = 50000000,
  parameter logic [N-1:0]   DEF_PATTERN = 8'b0000_0011,
  parameter int             DEF_LEN     = 4,
  parameter logic           DEF_OVERLAP = 1'b1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          w,
  input  logic [N-1:0]  cfg_pattern,
  input  logic [LW-1:0] cfg_len,
  input  logic          cfg_overlap,
  input  logic          cfg_load,
  output logic          z,
  output logic          tick,
  output logic [CW-1:0] match_count,
  output logic          cfg_err
);

  localparam int              CNTW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   CNT_MAX  = '1;

  logic [CNTW-1:0] tick_cnt_reg;
  logic            tick_hit;

  logic [N-1:0]    act_pattern_reg;
  logic [LW-1:0]   act_len_reg;
  logic            act_overlap_reg;
  logic [N-1:0]    hist_reg;
  logic [LW-1:0]   fill_reg;
  logic            z_reg;
  logic [CW-1:0]   count_reg;
  logic            cfg_err_reg;

  logic [N-1:0]    len_mask;
  logic [N-1:0]    hist_next;
  logic [LW-1:0]   fill_inc;
  logic            match;
  logic            cfg_ok;

  // Free-running divider; cfg_load never touches it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tick_cnt_reg <= '0;
    end else if (tick_cnt_reg == CNT_LAST) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  assign tick_hit = (tick_cnt_reg == CNT_LAST);
  assign tick     = tick_hit & ~Reset;

  // Only the low act_len bits of history and pattern take part in the compare.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign len_mask[gi] = (LW'(gi) < act_len_reg);
  end

  always_comb begin
    hist_next = {hist_reg[N-2:0], w};
    fill_inc  = (fill_reg < act_len_reg) ? fill_reg + 1'b1 : act_len_reg;
    match     = (fill_inc == act_len_reg) &&
                (((hist_next ^ act_pattern_reg) & len_mask) == '0);
    cfg_ok    = (cfg_len != '0) && (cfg_len <= LW'(N));
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      act_pattern_reg <= DEF_PATTERN;
      act_len_reg     <= LW'(DEF_LEN);
      act_overlap_reg <= DEF_OVERLAP;
      hist_reg        <= '0;
      fill_reg        <= '0;
      z_reg           <= 1'b0;
      count_reg       <= '0;
      cfg_err_reg     <= 1'b0;
    end else if (cfg_load) begin
      // A load always wins over a coincident tick; that sample is dropped.
      if (cfg_ok) begin
        act_pattern_reg <= cfg_pattern;
        act_len_reg     <= cfg_len;
        act_overlap_reg <= cfg_overlap;
        hist_reg        <= '0;
        fill_reg        <= '0;
        z_reg           <= 1'b0;
        count_reg       <= '0;
        cfg_err_reg     <= 1'b0;
      end else begin
        cfg_err_reg     <= 1'b1;
      end
    end else if (tick_hit) begin
      hist_reg <= hist_next;
      fill_reg <= (match && !act_overlap_reg) ? '0 : fill_inc;
      z_reg    <= match;
      if (match && (count_reg != CNT_MAX)) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign z           = z_reg;
  assign match_count = count_reg;
  assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_seq_det_moore_prog.sv
// Bench for seq_det_moore_prog: a per-cycle-sampling instance (CW=2) and
// a TICK_DIV=4 instance share all inputs.
module tb_seq_det_moore_prog;
  localparam int N  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          w;
  logic [N-1:0]  cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic          cfg_overlap;
  logic          cfg_load;

  logic          z1, tick1, err1;
  logic [1:0]    cnt1;
  logic          z4, tick4, err4;
  logic [7:0]    cnt4;

  always #5 clk = ~clk;

  seq_det_moore_prog #(.N(N), .LW(LW), .CW(2), .TICK_DIV(1)) dut1 (
    .Clock(clk), .Reset(rst), .w(w), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_load(cfg_load),
    .z(z1), .tick(tick1), .match_count(cnt1), .cfg_err(err1)
  );

  seq_det_moore_prog #(.N(N), .LW(LW), .CW(8), .TICK_DIV(4)) dut4 (
    .Clock(clk), .Reset(rst), .w(w), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_load(cfg_load),
    .z(z4), .tick(tick4), .match_count(cnt4), .cfg_err(err4)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic z;
    int   cnt;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One sample on dut1: expected result is queued with the stimulus and
  // retired after the edge that samples it.
  task automatic send(input logic b, input logic ez, input int ec, input string tag);
    exp_t e;
    w = b;
    e.z = ez;
    e.cnt = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " sb empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " z"}, 32'(z1), 32'(e.z));
      check({tag, " cnt"}, 32'(cnt1), 32'(e.cnt));
    end
  endtask

  task automatic load(input logic [N-1:0] pat, input logic [LW-1:0] len, input logic ov);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    @(posedge clk);
    #1;
    cfg_load    = 1'b0;
  endtask

  logic s4 [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int idx;
    rst = 1'b1; w = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cfg_load = 1'b0;
    #12;
    check("rst z1", 32'(z1), 0);    check("rst tick1", 32'(tick1), 0);
    check("rst cnt1", 32'(cnt1), 0); check("rst err1", 32'(err1), 0);
    check("rst z4", 32'(z4), 0);    check("rst tick4", 32'(tick4), 0);
    check("rst cnt4", 32'(cnt4), 0); check("rst err4", 32'(err4), 0);
    @(negedge clk) rst = 1'b0;

    // default 0011 detection
    send(0, 0, 0, "def b1"); send(0, 0, 0, "def b2");
    send(1, 0, 0, "def b3"); send(1, 1, 1, "def b4");
    send(0, 0, 1, "def b5");

    // rejected loads keep config and state; coincident sample is dropped
    w = 1'b1;
    load(8'h0F, 4'd0, 1'b1);
    check("len0 err", 32'(err1), 1); check("len0 cnt", 32'(cnt1), 1);
    load(8'h0F, 4'd9, 1'b1);
    check("len9 err", 32'(err1), 1); check("len9 z", 32'(z1), 0);
    send(0, 0, 1, "bad b1"); send(0, 0, 1, "bad b2");
    send(1, 0, 1, "bad b3"); send(1, 1, 2, "bad b4");

    // 101, overlap, upper pattern bits ignored
    load(8'b1111_0101, 4'd3, 1'b1);
    check("ld ov err", 32'(err1), 0); check("ld ov cnt", 32'(cnt1), 0);
    check("ld ov z", 32'(z1), 0);
    send(1, 0, 0, "ov b1"); send(0, 0, 0, "ov b2"); send(1, 1, 1, "ov b3");
    send(0, 0, 1, "ov b4"); send(1, 1, 2, "ov b5");

    // 101, non-overlap
    load(8'b1111_0101, 4'd3, 1'b0);
    check("ld nov cnt", 32'(cnt1), 0);
    send(1, 0, 0, "nov b1"); send(0, 0, 0, "nov b2"); send(1, 1, 1, "nov b3");
    send(0, 0, 1, "nov b4"); send(1, 0, 1, "nov b5");

    // len=1, back-to-back matches, counter saturates at 3
    load(8'h01, 4'd1, 1'b1);
    send(1, 1, 1, "sat b1"); send(1, 1, 2, "sat b2"); send(1, 1, 3, "sat b3");
    send(1, 1, 3, "sat b4"); send(1, 1, 3, "sat b5"); send(0, 0, 3, "sat b6");

    // async reset mid-pattern
    load(8'h03, 4'd4, 1'b1);
    send(0, 0, 0, "pre b1"); send(0, 0, 0, "pre b2");
    send(1, 0, 0, "pre b3"); send(1, 1, 1, "pre b4");
    send(0, 0, 1, "pre b5"); send(0, 0, 1, "pre b6"); send(1, 0, 1, "pre b7");
    load(8'h03, 4'd0, 1'b1);
    check("pre err", 32'(err1), 1);
    #3 rst = 1'b1;
    #1;
    check("arst z1", 32'(z1), 0);   check("arst tick1", 32'(tick1), 0);
    check("arst cnt1", 32'(cnt1), 0); check("arst err1", 32'(err1), 0);
    @(negedge clk); @(negedge clk) rst = 1'b0;
    send(1, 0, 0, "post b1"); send(0, 0, 0, "post b2"); send(0, 0, 0, "post b3");
    send(1, 0, 0, "post b4"); send(1, 1, 1, "post b5");

    // TICK_DIV=4 instance: tick cadence, ignored off-tick w, z width
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("d4 tick k0", 32'(tick4), 0);
    idx = 0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("d4 tick k%0d", k), 32'(tick4), 32'((k % 4) == 3));
      check($sformatf("d4 z k%0d", k), 32'(z4), 32'((k >= 16) && (k < 20)));
      if ((k % 4) == 3 && idx < 6) begin
        w = s4[idx];
        idx++;
      end else begin
        w = 1'($urandom);
      end
    end
    check("d4 cnt", 32'(cnt4), 1);
    check("d4 err", 32'(err4), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
